// File: rtl/vrased_reset_ctrl_pkg.sv
// Shared VRASED definitions: reset-controller state encoding, vector address, counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vrased_reset_ctrl_pkg;

  // Reset-controller FSM encoding
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_VEC = 2'd2
  } state_e;

  // Address the CPU fetches its reset vector from
  localparam logic [15:0] RESET_HANDLER_DEF = 16'hfffe;

  // Width of the violation-episode counter
  localparam int VIOL_CNT_W = 8;

  // Bits needed to hold a countdown value of 0..hold
  function automatic int hold_cnt_w(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/vrased_reset_ctrl_if.sv
// Bundle of violation inputs, CPU PC and the reset/cause status returned to the system.
// Latency: n/a (wires only).
// Backpressure: none; every signal is sampled or driven every cycle.
interface vrased_reset_ctrl_if #(
  parameter int NUM_SRC = 4
);
  import vrased_reset_ctrl_pkg::*;

  logic [NUM_SRC-1:0]    viol;
  logic [15:0]           pc;
  logic                  cause_clr;
  logic                  reset;
  logic [NUM_SRC-1:0]    cause;
  logic [VIOL_CNT_W-1:0] viol_cnt;
  logic                  busy;

  // System / monitor side: drives violations and PC, observes the reset status
  modport master (
    output viol, pc, cause_clr,
    input  reset, cause, viol_cnt, busy
  );

  // Reset-controller side
  modport slave (
    input  viol, pc, cause_clr,
    output reset, cause, viol_cnt, busy
  );

endinterface

// File: rtl/vrased_reset_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Latency: count updates one edge after i_inc.
// Backpressure: none; increments beyond the maximum are silently dropped.
module sat_counter
  import vrased_reset_ctrl_pkg::*;
#(
  parameter int W = VIOL_CNT_W
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == {W{1'b1}});

  // Clear wins over increment; increment holds once the counter is full
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset controller: turns any monitor violation into a held CPU reset until the reset vector is fetched.
// Latency: reset rises the cycle after the violation edge; stays high >= HOLD_CYCLES+1 cycles.
// Backpressure: none; violations during an episode re-arm the hold window instead of stalling.
module vrased_reset_ctrl
  import vrased_reset_ctrl_pkg::*;
#(
  parameter int          NUM_SRC       = 4,
  parameter int          HOLD_CYCLES   = 8,   // legal 1..255
  parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  vrased_reset_ctrl_if.slave bus
);

  localparam int              CNT_W     = hold_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_hold_cnt;
  logic                  r_reset;
  logic [NUM_SRC-1:0]    r_cause;
  logic [VIOL_CNT_W-1:0] w_viol_cnt;

  logic w_viol_any;
  logic w_at_vec;
  logic w_hold_done;
  logic w_busy;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_episode_start;
  logic w_cause_clr_ok;

  assign w_viol_any  = |bus.viol;
  assign w_at_vec    = (bus.pc == RESET_HANDLER);
  assign w_hold_done = (r_hold_cnt == '0);

  // State register; reset_n overrides every other input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: any violation (re)enters HOLD, which beats both the hold expiry and the vector fetch
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_viol_any) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_viol_any)       w_state_nxt = ST_HOLD;
        else if (w_hold_done) w_state_nxt = ST_WAIT_VEC;
      end
      ST_WAIT_VEC: begin
        if (w_viol_any)    w_state_nxt = ST_HOLD;
        else if (w_at_vec) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State-decoded controls for the datapath registers
  always_comb begin
    w_busy          = (r_state != ST_RUN);
    w_cnt_load      = w_viol_any;
    w_cnt_dec       = (r_state == ST_HOLD) && !w_hold_done;
    w_episode_start = (r_state == ST_RUN) && w_viol_any;
    w_cause_clr_ok  = (r_state == ST_RUN) && bus.cause_clr;
  end

  // Hold countdown: reloads on every violation, counts down only while holding
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_cnt <= '0;
    end else if (w_cnt_load) begin
      r_hold_cnt <= HOLD_LOAD;
    end else if (w_cnt_dec) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // CPU reset request follows the state being entered, so it rises with the HOLD entry edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_reset <= 1'b0;
    end else begin
      r_reset <= (w_state_nxt != ST_RUN);
    end
  end

  // Sticky cause; a clear in RUN replaces the old value with whatever arrives on the same edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cause <= '0;
    end else if (w_cause_clr_ok) begin
      r_cause <= bus.viol;
    end else begin
      r_cause <= r_cause | bus.viol;
    end
  end

  // Episode counter: one count per RUN->HOLD entry, re-arms inside an episode do not count
  sat_counter #(
    .W (VIOL_CNT_W)
  ) u_viol_cnt (
    .clk   (clk),
    .i_clr (!reset_n),
    .i_inc (w_episode_start),
    .o_cnt (w_viol_cnt)
  );

  assign bus.reset    = r_reset;
  assign bus.cause    = r_cause;
  assign bus.viol_cnt = w_viol_cnt;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench for vrased_reset_ctrl: driver pushes per-cycle expectations, monitor pops and compares.
// Latency: expectations apply to the outputs seen just after the edge that sampled the stimulus.
// Backpressure: n/a.
module tb_vrased_reset_ctrl;
  import vrased_reset_ctrl_pkg::*;

  localparam int          NSRC = 4;
  localparam int          H    = 4;
  localparam logic [15:0] RH   = 16'hfffe;

  typedef struct packed {
    logic       rst;
    logic       busy;
    logic [3:0] cause;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  vrased_reset_ctrl_if #(.NUM_SRC(NSRC)) bus ();

  vrased_reset_ctrl #(
    .NUM_SRC       (NSRC),
    .HOLD_CYCLES   (H),
    .RESET_HANDLER (RH)
  ) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: an episode is open from a violation until the PC reaches the
  // handler at least H+1 edges after the most recent violation.
  int         m_t      = 0;
  bit         m_in_ep  = 0;
  int         m_last_v = 0;
  logic [3:0] m_cause  = '0;
  int         m_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [15:0] p, input logic clr, input logic rn);
    exp_t e;
    @(negedge clk);
    bus.viol      = v;
    bus.pc        = p;
    bus.cause_clr = clr;
    rst_n         = rn;
    if (!rn) begin
      m_in_ep = 0;
      m_cause = '0;
      m_cnt   = 0;
    end else if (!m_in_ep) begin
      if (v != 0) begin
        m_in_ep  = 1;
        m_last_v = m_t;
        m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cause  = clr ? v : (m_cause | v);
      end else if (clr) begin
        m_cause = '0;
      end
    end else begin
      m_cause = m_cause | v;
      if (v != 0) m_last_v = m_t;
      else if ((m_t - m_last_v) >= H + 1 && p == RH) m_in_ep = 0;
    end
    m_t++;
    e.rst   = m_in_ep;
    e.busy  = m_in_ep;
    e.cause = m_cause;
    e.cnt   = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) step(4'b0000, p, 1'b0, 1'b1);
  endtask

  // Monitor: compares the DUT outputs one time unit after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("no_x_on_outputs", 32'($isunknown({bus.reset, bus.busy, bus.cause, bus.viol_cnt})), 32'd0);
        chk("reset",    32'(bus.reset),    32'(e.rst));
        chk("busy",     32'(bus.busy),     32'(e.busy));
        chk("cause",    32'(bus.cause),    32'(e.cause));
        chk("viol_cnt", 32'(bus.viol_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    bus.viol      = '0;
    bus.pc        = '0;
    bus.cause_clr = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    step(4'b0000, 16'h0000, 1'b0, 1'b0);
    step(4'b1111, 16'h0000, 1'b0, 1'b0);
    idle(2, 16'he000);

    // Basic episode: 4 hold cycles, wait for the vector, release
    step(4'b0010, 16'he000, 1'b0, 1'b1);
    idle(6, 16'he000);
    step(4'b0000, RH, 1'b0, 1'b1);
    idle(2, 16'he000);

    // Re-arm on the 3rd hold cycle
    step(4'b0000, 16'he000, 1'b1, 1'b1);
    step(4'b0010, 16'he000, 1'b0, 1'b1);
    idle(2, 16'he000);
    step(4'b0100, 16'he000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b0000, RH, 1'b0, 1'b1);
    idle(2, 16'he000);

    // Vector fetch and violation on the same edge in WAIT_VEC
    step(4'b1000, 16'he000, 1'b0, 1'b1);
    idle(5, 16'he000);
    step(4'b0001, RH, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(4'b0000, RH, 1'b0, 1'b1);

    // Mid-episode reset
    step(4'b1000, 16'he000, 1'b0, 1'b1);
    idle(2, 16'he000);
    step(4'b0000, 16'he000, 1'b0, 1'b0);
    idle(2, 16'he000);

    // cause_clr racing a new violation in RUN
    step(4'b0011, 16'he000, 1'b0, 1'b1);
    idle(5, 16'he000);
    step(4'b0000, RH, 1'b0, 1'b1);
    step(4'b1000, 16'he000, 1'b1, 1'b1);
    idle(5, 16'he000);
    step(4'b0000, RH, 1'b0, 1'b1);
    // cause_clr ignored while busy
    step(4'b0001, 16'he000, 1'b0, 1'b1);
    step(4'b0000, 16'he000, 1'b1, 1'b1);
    idle(5, 16'he000);
    step(4'b0000, RH, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic [3:0]  v;
      logic [15:0] p;
      v = ($urandom % 6 == 0) ? 4'($urandom) : 4'b0000;
      p = ($urandom % 3 == 0) ? RH : 16'($urandom);
      step(v, p, ($urandom % 8) == 0, ($urandom % 150) != 0);
    end

    // Saturation: 260 complete episodes
    step(4'b0000, 16'he000, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      step(4'($urandom_range(1, 15)), 16'he000, 1'b0, 1'b1);
      idle(5, 16'he000);
      step(4'b0000, RH, 1'b0, 1'b1);
    end
    idle(3, 16'he000);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
